// File: rtl/data_fetch_load.sv
// Load-path fetch engine: turns a slot address and dimension into a burst of memory reads and masked matrix rows.
// Latency: first row 2 cycles after start is sampled; FETCH_DONE N+2 cycles after start.
// Backpressure: none; rows stream at one per cycle, and dropping ADDR_START or raising ADDR_RST aborts the burst.
//
// Ports:
//   CLK, RSTN              clock, asynchronous active-low reset
//   DIMEN, ADDRESS         matrix dimension code (N = DIMEN+1) and 4-row slot index
//   ADDR_START, ADDR_RST   run request (level) and synchronous abort/clear
//   FETCH_DONE, BUSY       status back to the control unit
//   MEM_RE, MEM_ADDR       synchronous data-memory read port (data returns one cycle later)
//   MEM_RDATA              read data, element j in bits [8j+7:8j]
//   ROW_VALID, ROW_IDX     row strobe and row number
//   DATA_ROW               read data with elements j >= N forced to zero
module data_fetch_load #(
  parameter int MEM_AW = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [1:0]        DIMEN,
  input  logic [3:0]        ADDRESS,
  input  logic              ADDR_START,
  input  logic              ADDR_RST,
  output logic              FETCH_DONE,
  output logic              BUSY,
  output logic              MEM_RE,
  output logic [MEM_AW-1:0] MEM_ADDR,
  input  logic [31:0]       MEM_RDATA,
  output logic              ROW_VALID,
  output logic [1:0]        ROW_IDX,
  output logic [31:0]       DATA_ROW
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] dim_q, dim_d;
  logic [3:0] base_q, base_d;
  logic       row_vld_q, row_vld_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic       abort;
  logic [5:0] slot_addr;

  // Withdrawing the start request mid-burst is treated exactly like ADDR_RST.
  assign abort = ADDR_RST ||
                 (!ADDR_START && (state_q == S_READ || state_q == S_DRAIN));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dim_d   = dim_q;
    base_d  = base_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ADDR_START) begin
            state_d = S_READ;
            dim_d   = DIMEN;
            base_d  = ADDRESS;
            cnt_d   = 2'd0;
          end
        end
        S_READ: begin
          // CNT may wrap on the last row of an N=4 burst; it is unused until the next start.
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == dim_q) state_d = S_DRAIN;
        end
        S_DRAIN: state_d = S_DONE;
        default: state_d = S_DONE;  // DONE holds until an abort/clear
      endcase
    end
    // A read issued in the abort cycle has its returning data dropped.
    row_vld_d = (state_q == S_READ) && !abort;
    row_idx_d = cnt_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      dim_q     <= 2'd0;
      base_q    <= 4'd0;
      row_vld_q <= 1'b0;
      row_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dim_q     <= dim_d;
      base_q    <= base_d;
      row_vld_q <= row_vld_d;
      row_idx_q <= row_idx_d;
    end
  end

  // Status and memory port decode from registers only.
  assign MEM_RE     = (state_q == S_READ);
  assign BUSY       = (state_q == S_READ) || (state_q == S_DRAIN);
  assign FETCH_DONE = (state_q == S_DONE);
  assign ROW_VALID  = row_vld_q;
  assign ROW_IDX    = row_idx_q;

  // base + CNT stays inside the 4-row slot, so a 6-bit sum never carries.
  assign slot_addr = {base_q, 2'b00} + {4'b0000, cnt_q};

  always_comb begin
    MEM_ADDR = '0;
    if (MEM_RE) MEM_ADDR[5:0] = slot_addr;
  end

  always_comb begin
    DATA_ROW = '0;
    if (row_vld_q) begin
      for (int j = 0; j < 4; j++) begin
        if (2'(j) <= dim_q) DATA_ROW[8*j +: 8] = MEM_RDATA[8*j +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_fetch_load.sv
module tb_data_fetch_load;

  localparam int MEM_AW = 8;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic [1:0]        DIMEN = '0;
  logic [3:0]        ADDRESS = '0;
  logic              ADDR_START = 1'b0;
  logic              ADDR_RST = 1'b0;
  logic              FETCH_DONE;
  logic              BUSY;
  logic              MEM_RE;
  logic [MEM_AW-1:0] MEM_ADDR;
  logic [31:0]       MEM_RDATA = '0;
  logic              ROW_VALID;
  logic [1:0]        ROW_IDX;
  logic [31:0]       DATA_ROW;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  data_fetch_load #(.MEM_AW(MEM_AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .DIMEN(DIMEN), .ADDRESS(ADDRESS),
    .ADDR_START(ADDR_START), .ADDR_RST(ADDR_RST), .FETCH_DONE(FETCH_DONE),
    .BUSY(BUSY), .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .ROW_VALID(ROW_VALID), .ROW_IDX(ROW_IDX), .DATA_ROW(DATA_ROW)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory: data one cycle after a read, garbage otherwise.
  always @(posedge CLK) MEM_RDATA <= MEM_RE ? mem[MEM_ADDR] : $urandom;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] masked(input logic [31:0] w, input int n);
    logic [31:0] keep;
    keep = (n >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    return w & keep;
  endfunction

  task automatic test_reset();
    checks++;
    if ({MEM_RE, BUSY, FETCH_DONE, ROW_VALID} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got re/busy/done/vld=%b exp 0000", {MEM_RE, BUSY, FETCH_DONE, ROW_VALID});
    end
    checks++;
    if (MEM_ADDR !== '0 || ROW_IDX !== 2'd0 || DATA_ROW !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got addr=%0h idx=%0d row=%h exp 0/0/0", MEM_ADDR, ROW_IDX, DATA_ROW);
    end
  endtask

  // One LOADA/LOADB sequence as the control unit would run it. abort_at>0 aborts in that cycle
  // (via ADDR_RST or by dropping ADDR_START); otherwise FETCH_DONE is held 'extra' cycles
  // after it first rises and then cleared with an ADDR_RST pulse.
  task automatic run_fetch(input string name, input logic [1:0] dim, input logic [3:0] adr,
                           input int abort_at, input bit abort_by_rst, input int extra);
    int n;
    int base;
    int last;
    logic ere, erv, efd, ebusy;
    logic [31:0] edat;
    logic [MEM_AW-1:0] eaddr;
    logic [1:0] eidx;
    n    = int'(dim) + 1;
    base = int'(adr) * 4;
    last = (abort_at > 0) ? abort_at + 2 : n + 2 + extra;
    DIMEN = dim;
    ADDRESS = adr;
    ADDR_RST = 1'b0;
    ADDR_START = 1'b1;
    for (int c = 1; c <= last; c++) begin
      step();
      if (abort_at > 0 && c > abort_at) begin
        ere = 0; erv = 0; efd = 0; ebusy = 0;
      end else begin
        ere   = (c <= n);
        erv   = (c >= 2) && (c <= n + 1);
        efd   = (c >= n + 2);
        ebusy = (c <= n + 1);
      end
      edat  = erv ? masked(mem[base + c - 2], n) : 32'd0;
      eaddr = MEM_AW'(base + c - 1);
      eidx  = 2'(c - 2);
      checks++;
      if (MEM_RE !== ere) begin
        failures++;
        $display("FAIL %s mem_re c%0d got %b exp %b", name, c, MEM_RE, ere);
      end
      if (ere) begin
        checks++;
        if (MEM_ADDR !== eaddr) begin
          failures++;
          $display("FAIL %s mem_addr c%0d got %0d exp %0d", name, c, MEM_ADDR, eaddr);
        end
      end
      checks++;
      if (ROW_VALID !== erv) begin
        failures++;
        $display("FAIL %s row_valid c%0d got %b exp %b", name, c, ROW_VALID, erv);
      end
      if (erv) begin
        checks++;
        if (ROW_IDX !== eidx) begin
          failures++;
          $display("FAIL %s row_idx c%0d got %0d exp %0d", name, c, ROW_IDX, eidx);
        end
      end
      checks++;
      if (DATA_ROW !== edat) begin
        failures++;
        $display("FAIL %s data_row c%0d got %h exp %h", name, c, DATA_ROW, edat);
      end
      checks++;
      if (FETCH_DONE !== efd) begin
        failures++;
        $display("FAIL %s fetch_done c%0d got %b exp %b", name, c, FETCH_DONE, efd);
      end
      checks++;
      if (BUSY !== ebusy) begin
        failures++;
        $display("FAIL %s busy c%0d got %b exp %b", name, c, BUSY, ebusy);
      end
      // Inputs for the edge that ends cycle c.
      if (abort_at > 0 && c == abort_at) begin
        if (abort_by_rst) ADDR_RST = 1'b1;
        else ADDR_START = 1'b0;
      end else if (abort_at > 0 && c == abort_at + 1) begin
        ADDR_RST = 1'b0;
        ADDR_START = 1'b0;
      end else if (abort_at == 0 && c == last) begin
        ADDR_RST = 1'b1;
        ADDR_START = 1'b0;
      end
    end
    if (abort_at == 0) begin
      step();
      checks++;
      if ({FETCH_DONE, BUSY, MEM_RE, ROW_VALID} !== 4'b0000) begin
        failures++;
        $display("FAIL %s after_clear got done/busy/re/vld=%b exp 0000", name,
                 {FETCH_DONE, BUSY, MEM_RE, ROW_VALID});
      end
      ADDR_RST = 1'b0;
    end
  endtask

  task automatic test_idle_rst_and_start();
    ADDR_RST = 1'b1;
    ADDR_START = 1'b1;
    DIMEN = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({BUSY, MEM_RE, FETCH_DONE} !== 3'b000) begin
        failures++;
        $display("FAIL idle_rst_start cyc%0d got busy/re/done=%b exp 000", i, {BUSY, MEM_RE, FETCH_DONE});
      end
    end
    ADDR_RST = 1'b0;
    ADDR_START = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    DIMEN = 2'd3;
    ADDRESS = 4'd3;
    ADDR_START = 1'b1;
    step();
    step();
    #2 RSTN = 1'b0;
    #1;
    test_reset();
    ADDR_START = 1'b0;
    @(posedge CLK);
    #1 RSTN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({ROW_VALID, BUSY, MEM_RE} !== 3'b000) begin
        failures++;
        $display("FAIL post_reset cyc%0d got vld/busy/re=%b exp 000", i, {ROW_VALID, BUSY, MEM_RE});
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] dim;
    logic [3:0] adr;
    int ab;
    for (int i = 0; i < 12; i++) begin
      dim = 2'($urandom_range(0, 3));
      adr = 4'($urandom_range(0, 15));
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, int'(dim) + 2) : 0;
      run_fetch("rand", dim, adr, ab, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = $urandom;
    for (int k = 0; k < 4; k++) mem[8 + k] = 32'h1122_3344 + k;
    mem[0] = 32'hAABB_CCDD;
    mem[1] = 32'hAABB_CCDD;

    #12;
    test_reset();
    @(negedge CLK);
    RSTN = 1'b1;
    step();

    run_fetch("n4_slot2", 2'd3, 4'd2, 0, 1'b0, 1);
    run_fetch("n2_slot0", 2'd1, 4'd0, 0, 1'b0, 1);
    run_fetch("n1_hold", 2'd0, 4'd0, 0, 1'b0, 3);
    run_fetch("abort_rst", 2'd3, 4'd5, 2, 1'b1, 0);
    run_fetch("after_abort", 2'd3, 4'd5, 0, 1'b0, 1);
    run_fetch("abort_start", 2'd2, 4'd7, 3, 1'b0, 0);
    run_fetch("b2b_first", 2'd3, 4'd0, 0, 1'b0, 1);
    run_fetch("b2b_second", 2'd3, 4'd1, 0, 1'b0, 1);
    test_idle_rst_and_start();
    test_reset_mid_read();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_fetch_load.md
# data_fetch_load

Load-path data fetch engine driven by the SIMD control unit during LOADA/LOADB instructions. It converts a slot address and matrix dimension into a burst of synchronous data-memory reads. It then presents each returned row, zero-masked to the active dimension, to the processing-element matrix write ports. It signals FETCH_DONE back to the control unit when the last row has been delivered.

## Interface
- MEM_AW, default 8: data-memory word-address width; must be ≥ 6.
- CLK  in  1  system clock, all state updates on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- DIMEN  in  2  matrix dimension code; rows/columns N = DIMEN+1 (1..4).
- ADDRESS  in  4  matrix slot index; base word address = {ADDRESS, 2'b00}, zero-extended to MEM_AW.
- ADDR_START  in  1  level request to run a fetch; sampled in IDLE only.
- ADDR_RST  in  1  synchronous abort/clear; returns FSM to IDLE from any state.
- FETCH_DONE  out  1  high while in DONE.
- BUSY  out  1  high in READ and DRAIN.
- MEM_RE  out  1  data-memory read enable.
- MEM_ADDR  out  MEM_AW  data-memory word address.
- MEM_RDATA  in  32  read data, valid exactly one cycle after MEM_RE; element j in bits [8j+7:8j].
- ROW_VALID  out  1  DATA_ROW/ROW_IDX valid this cycle.
- ROW_IDX  out  2  row number 0..N-1 of DATA_ROW.
- DATA_ROW  out  32  MEM_RDATA with elements j ≥ N forced to 0.

## Operation
- States: IDLE, READ, DRAIN, DONE. Registered state, 2-bit row counter CNT, latched N and base.
- IDLE: ADDR_START=1 and ADDR_RST=0 at edge → latch DIMEN, ADDRESS, clear CNT, go READ.
- READ: MEM_RE=1, MEM_ADDR=base+CNT. CNT increments each cycle. When CNT==N-1, go DRAIN.
- DRAIN: MEM_RE=0. Waits one cycle so the last row's data returns. Next state is DONE.
- DONE: FETCH_DONE=1. Stays in DONE until ADDR_RST=1, then goes to IDLE. ADDR_START is ignored in DONE, so there is no auto-restart.
- ADDR_RST=1 has priority over every transition. It forces IDLE and clears CNT. Outstanding read data is discarded: ROW_VALID is suppressed in the cycle after the abort.
- ADDR_START falling in READ/DRAIN: treated as an abort, same as ADDR_RST.
- ROW_VALID is a registered copy of MEM_RE, gated by the abort rule above. ROW_IDX is the registered copy of CNT.
- DATA_ROW is the combinational mask of MEM_RDATA using the latched N. It is 0 when ROW_VALID=0.
- Address arithmetic: base+CNT never exceeds base+3, so it cannot leave the 4-row slot and there is no wrap. ADDRESS values above the memory size are not checked.
- MEM_RE, MEM_ADDR, BUSY and FETCH_DONE decode from state/CNT registers only. There is no input-to-output combinational path except MEM_RDATA→DATA_ROW.

## Timing
- Reset (RSTN low, asynchronous): state IDLE, CNT=0, ROW_VALID=0, ROW_IDX=0, MEM_RE=0, MEM_ADDR=0, FETCH_DONE=0, BUSY=0, DATA_ROW=0. Latched N=1, base=0.
- Cycle numbering for a fetch: ADDR_START is sampled at edge 0.
  - Cycles 1..N: READ, with MEM_RE=1 and addresses base..base+N-1.
  - Cycles 2..N+1: ROW_VALID=1 with ROW_IDX 0..N-1.
  - Cycle N+1: DRAIN.
  - Cycle N+2 onward: FETCH_DONE=1.
  - Latency from start to FETCH_DONE is N+2 cycles.
- Control-unit handshake: the control unit registers FETCH_DONE and drives ADDR_RST=1 / ADDR_START=0 in the following cycle. FETCH_DONE is therefore high for exactly 2 cycles in normal flow. The FSM is in IDLE the cycle after ADDR_RST is sampled.
- ADDR_START and ADDR_RST both high in IDLE: stays IDLE.
- Back-to-back loads: the earliest new start is sampled at the first edge with the FSM in IDLE and ADDR_RST=0.

## Test plan
- Reset mid-READ: assert RSTN=0 asynchronously during READ (N=4) → all outputs immediately at reset values; no ROW_VALID after release.
- DIMEN=3, ADDRESS=2, memory rows 8..11 = 0x11223344+k → MEM_ADDR 8,9,10,11 in cycles 1-4. ROW_VALID cycles 2-5 with DATA_ROW equal to the stored words and ROW_IDX 0-3. FETCH_DONE from cycle 6.
- DIMEN=1, ADDRESS=0, row data 0xAABBCCDD → MEM_RE for 2 cycles (addresses 0,1). DATA_ROW=0x0000CCDD. FETCH_DONE at cycle 4.
- DIMEN=0 → single read, DATA_ROW=0x000000DD. FETCH_DONE at cycle 3. FETCH_DONE held while ADDR_RST=0 and ADDR_START=1; clears the cycle after ADDR_RST=1.
- ADDR_RST=1 in cycle 2 of an N=4 fetch → IDLE next cycle, MEM_RE=0, no further ROW_VALID, FETCH_DONE never asserted. A subsequent start runs a full fetch correctly.
- Two LOAD sequences emulating the control unit (start, FETCH_DONE→ADDR_RST pulse, start again with ADDRESS=1) → the second burst reads 4..7 with no lost or duplicated rows.
